prio_encoder8x3_q: RTL and testbench

- Sequential 8-to-3 priority encoder with sticky request capture. It is the encode-side counterpart of the 3x8 one-hot decoder.
- Eight request lines are latched into a pending register. The block presents the 3-bit index of the selected pending request on a valid/ready handshake and clears that request when it is accepted.
- It sits between event sources (interrupt or request lines) and a consumer that takes one binary index at a time.

---
 rtl/pe_pkg.sv | 15 +
 rtl/prio_pick8.sv | 36 +++
 rtl/prio_encoder8x3_q.sv | 97 +++++++++
 tb/tb_prio_encoder8x3_q.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and types for the 8-to-3 sticky priority encoder.
package pe_pkg;

  localparam int PE_N = 8;
  localparam int PE_W = 3;

  localparam logic PE_FIXED = 1'b0;
  localparam logic PE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } pe_state_e;

endpackage

// File: rtl/prio_pick8.sv
// Combinational picker: highest set bit (fixed) or first set bit from start (round-robin).
module prio_pick8
  import pe_pkg::*;
(
  input  logic [PE_N-1:0] req,
  input  logic [PE_W-1:0] start,
  input  logic            mode,
  output logic [PE_W-1:0] idx,
  output logic            any
);

  logic            found;
  logic [PE_W-1:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    any   = |req;
    if (mode == PE_FIXED) begin
      // Ascending scan, so the last hit is the highest index.
      for (int i = 0; i < PE_N; i++) begin
        if (req[i]) idx = PE_W'(i);
      end
    end else begin
      for (int k = 0; k < PE_N; k++) begin
        pos = start + PE_W'(k);
        if (!found && req[pos]) begin
          idx   = pos;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_encoder8x3_q.sv
// Sticky 8-to-3 priority encoder: latches requests, presents one index per valid/ready accept.
module prio_encoder8x3_q
  import pe_pkg::*;
#(
  parameter int RR = 0,
  parameter int N  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in,
  input  logic            en,
  output logic [PE_W-1:0] out,
  output logic            valid,
  input  logic            ready,
  output logic [N-1:0]    pend,
  output logic            ovf
);

  if (N != PE_N) begin : g_n_check
    $error("prio_encoder8x3_q supports only N = 8");
  end

  pe_state_e       state_q, state_d;
  logic [PE_N-1:0] pend_q, pend_d;
  logic [PE_W-1:0] out_q, out_d;
  logic [PE_W-1:0] last_q, last_d;
  logic            ovf_q, ovf_d;

  logic            acc;
  logic [PE_N-1:0] clr, set, rem, pick_req;
  logic [PE_W-1:0] pick_start, pick_idx;
  logic            pick_any;

  assign valid = (state_q == ST_PRESENT);
  assign out   = out_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;

  assign acc = valid && ready;
  assign clr = acc ? (PE_N'(1) << out_q) : '0;
  assign set = in & {PE_N{en}};
  assign rem = pend_q & ~clr;

  // While presenting, the next pick looks at what survives this accept and
  // starts just past the index being accepted; the same-cycle set is excluded.
  assign pick_req   = (state_q == ST_PRESENT) ? rem : pend_q;
  assign pick_start = (state_q == ST_PRESENT) ? out_q + 3'd1 : last_q + 3'd1;

  prio_pick8 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .mode  ((RR != 0) ? PE_RR : PE_FIXED),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pend_d  = rem | set;
    ovf_d   = |(set & rem);
    state_d = state_q;
    out_d   = out_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          out_d   = pick_idx;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (acc) begin
          last_d = out_q;
          if (pick_any) out_d = pick_idx;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      out_q   <= '0;
      last_q  <= 3'd7;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_prio_encoder8x3_q.sv
// Bench for prio_encoder8x3_q: fixed and round-robin instances against a behavioural model.
module tb_prio_encoder8x3_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_s;
  logic       en;
  logic       ready;

  logic [2:0] out_f, out_r;
  logic       valid_f, valid_r, ovf_f, ovf_r;
  logic [7:0] pend_f, pend_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_encoder8x3_q #(.RR(0), .N(8)) u_fix (
    .clk(clk), .rst_n(rst_n), .in(in_s), .en(en), .out(out_f),
    .valid(valid_f), .ready(ready), .pend(pend_f), .ovf(ovf_f)
  );

  prio_encoder8x3_q #(.RR(1), .N(8)) u_rr (
    .clk(clk), .rst_n(rst_n), .in(in_s), .en(en), .out(out_r),
    .valid(valid_r), .ready(ready), .pend(pend_r), .ovf(ovf_r)
  );

  // Reference state per instance: index 0 = fixed priority, 1 = round-robin.
  logic [7:0] m_pend  [2];
  logic [2:0] m_out   [2];
  logic [2:0] m_last  [2];
  logic       m_valid [2];
  logic       m_ovf   [2];

  function automatic logic [2:0] ref_pick(input logic [7:0] x, input int rr, input logic [2:0] last);
    if (rr == 0) begin
      for (int i = 7; i >= 0; i--) if (x[i]) return 3'(i);
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int j;
        j = (int'(last) + k) % 8;
        if (x[j]) return 3'(j);
      end
    end
    return 3'd0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_pend[r] = 8'h00; m_out[r] = 3'd0; m_last[r] = 3'd7;
      m_valid[r] = 1'b0; m_ovf[r] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int r = 0; r < 2; r++) begin
      logic [7:0] clr, setv, rem;
      logic       acc;
      acc  = m_valid[r] && ready;
      clr  = acc ? (8'h01 << m_out[r]) : 8'h00;
      setv = en ? in_s : 8'h00;
      rem  = m_pend[r] & ~clr;
      m_ovf[r] = |(setv & m_pend[r] & ~clr);
      if (!m_valid[r]) begin
        if (m_pend[r] != 8'h00) begin
          m_out[r]   = ref_pick(m_pend[r], r, m_last[r]);
          m_valid[r] = 1'b1;
        end
      end else if (acc) begin
        m_last[r] = m_out[r];
        if (rem != 8'h00) m_out[r] = ref_pick(rem, r, m_last[r]);
        else              m_valid[r] = 1'b0;
      end
      m_pend[r] = rem | setv;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("fix_pend",  32'(pend_f),  32'(m_pend[0]));
    chk("fix_valid", 32'(valid_f), 32'(m_valid[0]));
    chk("fix_ovf",   32'(ovf_f),   32'(m_ovf[0]));
    if (m_valid[0]) chk("fix_out", 32'(out_f), 32'(m_out[0]));
    chk("rr_pend",   32'(pend_r),  32'(m_pend[1]));
    chk("rr_valid",  32'(valid_r), 32'(m_valid[1]));
    chk("rr_ovf",    32'(ovf_r),   32'(m_ovf[1]));
    if (m_valid[1]) chk("rr_out", 32'(out_r), 32'(m_out[1]));
  endtask

  // Advance one edge; inputs are changed only at edge+1 so they are stable at the edge.
  task automatic cycle();
    if (rst_n) model_step();
    else       model_reset();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [7:0] i, input logic e, input logic r);
    in_s = i; en = e; ready = r;
  endtask

  initial begin
    drive(8'h00, 1'b1, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_pend",  32'(pend_f),  32'h00);
    chk("rst_valid", 32'(valid_f), 32'h0);
    chk("rst_out",   32'(out_f),   32'h0);
    chk("rst_ovf",   32'(ovf_f),   32'h0);
    cycle();
    rst_n = 1'b1;

    // Single request: pend after 1 edge, valid after 2, drained after 3.
    drive(8'h04, 1'b1, 1'b1);
    cycle();
    chk("t1_pend_e1", 32'(pend_f), 32'h04);
    drive(8'h00, 1'b1, 1'b1);
    cycle();
    chk("t1_out_e2",   32'(out_f),   32'd2);
    chk("t1_valid_e2", 32'(valid_f), 32'd1);
    cycle();
    chk("t1_pend_e3",  32'(pend_f),  32'h00);
    chk("t1_valid_e3", 32'(valid_f), 32'd0);
    cycle();

    // Stall with 0x91 pending, then drain 7, 4, 0 on the fixed instance.
    drive(8'h91, 1'b1, 1'b0);
    cycle();
    drive(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t2_hold_out", 32'(out_f), 32'd7);
    drive(8'h00, 1'b1, 1'b1);
    cycle(); chk("t2_seq4", 32'(out_f), 32'd4);
    cycle(); chk("t2_seq0", 32'(out_f), 32'd0);
    cycle(); chk("t2_idle", 32'(valid_f), 32'd0);
    for (int i = 0; i < 3; i++) cycle();

    // Round-robin sweep over 0xFF, then 0x81 arriving after 7 is granted.
    drive(8'hFF, 1'b1, 1'b1);
    cycle();
    drive(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (m_valid[1] && m_out[1] == 3'd7) begin
        drive(8'h81, 1'b1, 1'b1);
        cycle();
        drive(8'h00, 1'b1, 1'b1);
      end
    end
    for (int i = 0; i < 10; i++) cycle();

    // Overflow on a stalled pending bit, then set-wins on the accept cycle.
    drive(8'h20, 1'b1, 1'b0);
    cycle();
    drive(8'h00, 1'b1, 1'b0);
    cycle(); cycle();
    drive(8'h20, 1'b1, 1'b0);
    cycle();
    chk("t4_ovf", 32'(ovf_f), 32'd1);
    drive(8'h00, 1'b1, 1'b0);
    cycle();
    chk("t4_ovf_pulse", 32'(ovf_f), 32'd0);
    drive(8'h20, 1'b1, 1'b1);
    cycle();
    chk("t4_setwins", 32'(pend_f), 32'h20);
    drive(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle();

    // Capture disabled while lines are all high.
    drive(8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle();
    chk("t5_no_cap", 32'(pend_f), 32'h00);
    drive(8'h12, 1'b1, 1'b1);
    cycle();
    chk("t5_cap", 32'(pend_f), 32'h12);
    drive(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle();

    // Asynchronous reset while presenting with 0x30 pending.
    drive(8'h30, 1'b1, 1'b0);
    cycle();
    drive(8'h00, 1'b1, 1'b0);
    cycle(); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_arst_valid", 32'(valid_f), 32'd0);
    chk("t6_arst_pend",  32'(pend_f),  32'h00);
    chk("t6_arst_out",   32'(out_f),   32'd0);
    cycle();
    rst_n = 1'b1;
    drive(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic: sparse requests, random enable and backpressure.
    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom) & 8'($urandom) & 8'($urandom),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
